mem_stage_lsu: RTL and testbench

Load/store unit for the MEM pipeline stage: the initiator that drives the 8-word data memory's read and write ports. It accepts one load or store request at a time from the EX/MEM stage and performs MIPS byte, halfword and word accesses. Sub-word stores use a registered read-modify-write. Each request returns a single-cycle completion pulse, with sign- or zero-extended load data, to the writeback path.

---
 rtl/mem_stage_lsu.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one request at a time; byte/half/word loads and stores,
// sub-word stores via read-modify-write. Optional macro LSU_MISALIGN_CHECK_EN adds an error check.
module mem_stage_lsu #(
  parameter int unsigned MEM_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [2:0]  mem_read_addr,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable
);

  typedef enum logic [2:0] {
    StIdle, StRead, StRmwRead, StRmwWrite, StWrite, StResp
  } state_e;

  localparam logic [2:0] IdxMask = 3'(MEM_WORDS - 1);

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        misalign;
  logic [2:0]  word_idx;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic        unused_addr;

  // Upper address bits alias onto the 8-word window.
  assign unused_addr = ^req_addr[31:5];

  assign accept   = req_valid && req_ready;
  assign word_idx = addr_q[4:2] & IdxMask;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_size == 2'd1) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    half_lane = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    byte_lane = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    if (size_q[1]) begin
      load_ext = mem_read_data;
    end else if (size_q == 2'd1) begin
      load_ext = {{16{half_lane[15] & ~uns_q}}, half_lane};
    end else begin
      load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
    end
  end

  always_comb begin
    merged = merge_q;
    if (size_q == 2'd1) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = 32'h0;
    resp_rd          = 5'h0;
    resp_err         = 1'b0;
    mem_read_enable  = 1'b0;
    mem_read_addr    = 3'h0;
    mem_write_enable = 1'b0;
    mem_write_addr   = 3'h0;
    mem_write_data   = 32'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = !rst;
        if (accept) begin
          if (misalign)                state_d = StResp;
          else if (!req_we)            state_d = StRead;
          else if (req_size[1])        state_d = StWrite;
          else                         state_d = StRmwRead;
        end
      end
      StRead: begin
        mem_read_enable = 1'b1;
        mem_read_addr   = word_idx;
        state_d         = StResp;
      end
      StRmwRead: begin
        mem_read_enable = 1'b1;
        mem_read_addr   = word_idx;
        state_d         = StRmwWrite;
      end
      StRmwWrite: begin
        mem_write_enable = 1'b1;
        mem_write_addr   = word_idx;
        mem_write_data   = merged;
        state_d          = StResp;
      end
      StWrite: begin
        mem_write_enable = 1'b1;
        mem_write_addr   = word_idx;
        mem_write_data   = wdata_q;
        state_d          = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_rd    = rd_q;
        resp_err   = err_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 5'h0;
      wdata_q <= 32'h0;
      rd_q    <= 5'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[4:0];
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        rdata_q <= 32'h0;
        err_q   <= misalign;
      end
      if (state_q == StRead && !we_q) rdata_q <= load_ext;
      if (state_q == StRmwRead)       merge_q <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a behavioural 8-word data memory.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [2:0]  mem_read_addr;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;
  logic [2:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;

  mem_stage_lsu #(.MEM_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_read_addr(mem_read_addr), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  // Data memory model; preload port lets the bench seed words without touching the DUT.
  logic [31:0] mem [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = 3'h0;
  logic [31:0] pre_data = 32'h0;
  assign mem_read_data = mem[mem_read_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    logic [31:0] cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int resp_seen = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_rcyc = 0;
  int last_wcyc = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [2:0]  last_waddr = 3'h0;
  int last_accept = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT pulses resp_valid.
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got rd %0d rdata %h expected no response", resp_rd,
                 resp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_rd", {27'h0, resp_rd}, {27'h0, e.rd});
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Memory-port monitor.
  always @(negedge clk) begin
    chk("rd_wr_exclusive", {31'h0, mem_read_enable && mem_write_enable}, 32'h0);
    if (mem_read_enable) begin
      rd_cnt++;
      last_rcyc = cyc;
    end else begin
      chk("read_addr_idle", {29'h0, mem_read_addr}, 32'h0);
    end
    if (mem_write_enable) begin
      wr_cnt++;
      last_wcyc  = cyc;
      last_wdata = mem_write_data;
      last_waddr = mem_write_addr;
    end else begin
      chk("write_data_idle", mem_write_data, 32'h0);
    end
  end

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input int exp_reads, input int exp_writes);
    int s0, r0, w0;
    bit got;
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    s0 = resp_seen; r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    last_accept = cyc;
    e.rdata = exp_rdata; e.rd = rd; e.err = exp_err; e.cyc = 32'(cyc + lat - 1);
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (resp_seen != s0) begin
        got = 1'b1;
        break;
      end
    end
    chk("resp_arrived", {31'h0, got}, 32'h1);
    chk("read_strobes", 32'(rd_cnt - r0), 32'(exp_reads));
    chk("write_strobes", 32'(wr_cnt - w0), 32'(exp_writes));
    if (!got) exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0;
    // Reset values.
    #3;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_rd", {27'h0, resp_rd}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_en", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
    chk("rst_mem_addr", {26'h0, mem_read_addr, mem_write_addr}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    preload(3'd3, 32'h8000_00F4);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, 5'd5,  32'h8000_00F4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_000C, 32'h0, 5'd6,  32'hFFFF_FFF4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_000C, 32'h0, 5'd7,  32'h0000_00F4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_000E, 32'h0, 5'd8,  32'hFFFF_8000, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h0000_000E, 32'h0, 5'd9,  32'h0000_8000, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_000F, 32'h0, 5'd10, 32'hFFFF_FF80, 1'b0, 2, 1, 0);

    // Sub-word store: read at T+1, write at T+2, response at T+3.
    preload(3'd3, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h0000_000D, 32'hFFFF_FFAB, 5'd11, 32'h0, 1'b0, 3, 1, 1);
    chk("sb_read_cycle", 32'(last_rcyc), 32'(last_accept));
    chk("sb_write_cycle", 32'(last_wcyc), 32'(last_accept + 1));
    chk("sb_write_data", last_wdata, 32'h1122_AB44);
    chk("sb_write_addr", {29'h0, last_waddr}, 32'd3);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, 5'd12, 32'h1122_AB44, 1'b0, 2, 1, 0);

    issue(1'b1, 2'd2, 1'b0, 32'h0000_001C, 32'hDEAD_BEEF, 5'd13, 32'h0, 1'b0, 2, 0, 1);
    chk("sw_write_addr", {29'h0, last_waddr}, 32'd7);
    chk("sw_write_data", last_wdata, 32'hDEAD_BEEF);
    chk("sw_write_cycle", 32'(last_wcyc), 32'(last_accept));
    issue(1'b0, 2'd2, 1'b0, 32'h0000_003C, 32'h0, 5'd14, 32'hDEAD_BEEF, 1'b0, 2, 1, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_003E, 32'h1234_5566, 5'd15, 32'h0, 1'b0, 3, 1, 1);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_001C, 32'h0, 5'd16, 32'h5566_BEEF, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, 5'd17, 32'h0000_5566, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd3, 1'b0, 32'h0000_000C, 32'h0, 5'd18, 32'h1122_AB44, 1'b0, 2, 1, 0);

    // Misaligned accesses.
    preload(3'd1, 32'h0123_4567);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 5'd19, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_000D, 32'h0, 5'd20, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0005, 32'h5A5A_5A5A, 5'd21, 32'h0, 1'b1, 1, 0, 0);
`else
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 5'd19, 32'h0123_4567, 1'b0, 2, 1, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_000D, 32'h0, 5'd20, 32'hFFFF_AB44, 1'b0, 2, 1, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0005, 32'h5A5A_5A5A, 5'd21, 32'h0, 1'b0, 2, 0, 1);
    chk("forced_align_waddr", {29'h0, last_waddr}, 32'd1);
    preload(3'd1, 32'h0123_4567);
`endif
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 5'd22, 32'h0123_4567, 1'b0, 2, 1, 0);

    // Reset during RMW_READ of a halfword store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h0000_000C; req_wdata = 32'h0000_7777; req_rd = 5'd23;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_in_rmw_read", {31'h0, mem_read_enable}, 32'h1);
    w0 = wr_cnt;
    s0 = resp_seen;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", {31'h0, req_ready}, 32'h0);
    chk("abort_strobes_drop", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
    chk("abort_no_write", 32'(wr_cnt - w0), 32'h0);
    chk("abort_no_resp", 32'(resp_seen - s0), 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, 5'd24, 32'h1122_AB44, 1'b0, 2, 1, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
